// File: rtl/core_mul.sv
// ---------------------------------------------------------------------------
// core_mul
//   Iterative multiply / multiply-accumulate unit fed by core_control.
//   Handles MUL/MLA (32-bit result) and UMULL/SMULL/UMLAL/SMLAL (64-bit).
//   Each RUN cycle retires STEP_BITS bits of the multiplier. Signed long
//   operations multiply magnitudes and negate the product at the end.
//   The 32-bit forms use the raw operands, because the low word of a
//   product does not depend on the operands' signedness.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   mul_a, mul_b          multiplicand / multiplier
//   mul_c_hi, mul_c_lo    accumulator words (c_hi used for long+add only)
//   mul_add               accumulate C into the product
//   mul_long              1: 64-bit result, 0: 32-bit result in q_lo
//   mul_signed            two's-complement operands (long forms only)
//   mul_start             command strobe, sampled only while mul_ready=1
//   mul_ready             idle; q valid and held
//   mul_q_hi, mul_q_lo    result words
// ---------------------------------------------------------------------------
module core_mul #(
    parameter int STEP_BITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mul_a,
    input  logic [31:0] mul_b,
    input  logic [31:0] mul_c_hi,
    input  logic [31:0] mul_c_lo,
    input  logic        mul_add,
    input  logic        mul_long,
    input  logic        mul_signed,
    input  logic        mul_start,
    output logic        mul_ready,
    output logic [31:0] mul_q_hi,
    output logic [31:0] mul_q_lo
);

    localparam int STEPS = 32 / STEP_BITS;
    localparam int CW    = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [63:0]     a_sh_q,  a_sh_d;   // |a| shifted up by the bits already retired
    logic [31:0]     b_sh_q,  b_sh_d;   // |b| shifted down; low slice is the current digit
    logic [63:0]     acc_q,   acc_d;    // unsigned partial product
    logic [63:0]     c_q,     c_d;
    logic            add_q,   add_d;
    logic            long_q,  long_d;
    logic            neg_q,   neg_d;
    logic [63:0]     q_q,     q_d;

    logic            use_mag;
    logic [31:0]     a_mag;
    logic [31:0]     b_mag;
    logic [63:0]     digit;
    logic [63:0]     prod;
    logic [31:0]     lo_sum;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        c_d     = c_q;
        add_d   = add_q;
        long_d  = long_q;
        neg_d   = neg_q;
        q_d     = q_q;

        use_mag = mul_signed & mul_long;
        a_mag   = (use_mag && mul_a[31]) ? -mul_a : mul_a;
        b_mag   = (use_mag && mul_b[31]) ? -mul_b : mul_b;
        digit   = 64'(b_sh_q[STEP_BITS-1:0]);
        prod    = neg_q ? -acc_q : acc_q;
        lo_sum  = prod[31:0] + (add_q ? c_q[31:0] : 32'd0);

        unique case (state_q)
            S_IDLE: begin
                if (mul_start) begin
                    a_sh_d  = {32'd0, a_mag};
                    b_sh_d  = b_mag;
                    acc_d   = 64'd0;
                    cnt_d   = CW'(STEPS - 1);
                    c_d     = {mul_c_hi, mul_c_lo};
                    add_d   = mul_add;
                    long_d  = mul_long;
                    neg_d   = use_mag & (mul_a[31] ^ mul_b[31]);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d  = acc_q + a_sh_q * digit;
                a_sh_d = a_sh_q << STEP_BITS;
                b_sh_d = b_sh_q >> STEP_BITS;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                if (long_q) begin
                    q_d = prod + (add_q ? c_q : 64'd0);
                end else begin
                    q_d = {32'd0, lo_sum};
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            add_q   <= 1'b0;
            long_q  <= 1'b0;
            neg_q   <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            add_q   <= add_d;
            long_q  <= long_d;
            neg_q   <= neg_d;
            q_q     <= q_d;
        end
    end

    assign mul_ready = (state_q == S_IDLE);
    assign mul_q_hi  = q_q[63:32];
    assign mul_q_lo  = q_q[31:0];

endmodule

// File: tb/tb_core_mul.sv
// ---------------------------------------------------------------------------
// tb_core_mul
//   Directed testbench for core_mul (STEP_BITS=2, 17-cycle latency).
//   Inputs are driven on the falling edge; outputs are sampled 1 time unit
//   after the rising edge.
// ---------------------------------------------------------------------------
module tb_core_mul;

    logic        clk;
    logic        rst_n;
    logic [31:0] mul_a, mul_b, mul_c_hi, mul_c_lo;
    logic        mul_add, mul_long, mul_signed, mul_start;
    logic        mul_ready;
    logic [31:0] mul_q_hi, mul_q_lo;

    int n_checks;
    int n_fail;

    localparam int LAT = 17;

    core_mul #(.STEP_BITS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_c_hi   (mul_c_hi),
        .mul_c_lo   (mul_c_lo),
        .mul_add    (mul_add),
        .mul_long   (mul_long),
        .mul_signed (mul_signed),
        .mul_start  (mul_start),
        .mul_ready  (mul_ready),
        .mul_q_hi   (mul_q_hi),
        .mul_q_lo   (mul_q_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command at the falling edge; it is taken at the next rising edge (E0).
    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] chi, input logic [31:0] clo,
                          input logic add, input logic lng, input logic sgn);
        @(negedge clk);
        mul_a      = a;
        mul_b      = b;
        mul_c_hi   = chi;
        mul_c_lo   = clo;
        mul_add    = add;
        mul_long   = lng;
        mul_signed = sgn;
        mul_start  = 1'b1;
        @(posedge clk);
        #1;
        mul_start  = 1'b0;
    endtask

    // Counts rising edges after E0 until mul_ready; bounded.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!mul_ready && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset_state;
        n_checks++;
        if (mul_ready !== 1'b1 || mul_q_hi !== 32'd0 || mul_q_lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b q=%h_%h, need ready=1 q=0_0",
                     mul_ready, mul_q_hi, mul_q_lo);
        end
    endtask

    task automatic test_umull;
        int cyc;
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (mul_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL umull_busy: ready=%b, need 0", mul_ready);
        end
        n_checks++;
        if (mul_q_lo !== 32'd0) begin
            n_fail++;
            $display("FAIL umull_q_held_early: q_lo=%h, need 0", mul_q_lo);
        end
        wait_ready(cyc);
        n_checks++;
        if (cyc !== LAT) begin
            n_fail++;
            $display("FAIL umull_latency: got %0d cycles, need %0d", cyc, LAT);
        end
        n_checks++;
        if (mul_q_hi !== 32'hFFFFFFFE || mul_q_lo !== 32'h00000001) begin
            n_fail++;
            $display("FAIL umull_result: q=%h_%h, need FFFFFFFE_00000001", mul_q_hi, mul_q_lo);
        end
        // The result holds through idle cycles.
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mul_ready !== 1'b1 || mul_q_hi !== 32'hFFFFFFFE || mul_q_lo !== 32'h00000001) begin
            n_fail++;
            $display("FAIL umull_hold: ready=%b q=%h_%h, need 1 FFFFFFFE_00000001",
                     mul_ready, mul_q_hi, mul_q_lo);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        launch(32'd9, 32'd9, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mul_ready !== 1'b1 || mul_q_hi !== 32'd0 || mul_q_lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: ready=%b q=%h_%h, need ready=1 q=0_0",
                     mul_ready, mul_q_hi, mul_q_lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(32'd2, 32'd3, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        wait_ready(cyc);
        n_checks++;
        if (cyc !== LAT || mul_q_hi !== 32'd0 || mul_q_lo !== 32'd6) begin
            n_fail++;
            $display("FAIL reset_restart: cyc=%0d q=%h_%h, need %0d 00000000_00000006",
                     cyc, mul_q_hi, mul_q_lo, LAT);
        end
    endtask

    task automatic test_smull;
        int cyc;
        launch(32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        wait_ready(cyc);
        n_checks++;
        if (mul_q_hi !== 32'hFFFFFFFF || mul_q_lo !== 32'hFFFFFFF1) begin
            n_fail++;
            $display("FAIL smull_neg3x5: q=%h_%h, need FFFFFFFF_FFFFFFF1", mul_q_hi, mul_q_lo);
        end
        launch(32'h80000000, 32'h80000000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        wait_ready(cyc);
        n_checks++;
        if (mul_q_hi !== 32'h40000000 || mul_q_lo !== 32'h0) begin
            n_fail++;
            $display("FAIL smull_min_sq: q=%h_%h, need 40000000_00000000", mul_q_hi, mul_q_lo);
        end
        // Same bit pattern, signed vs unsigned long.
        launch(32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        wait_ready(cyc);
        n_checks++;
        if (mul_q_hi !== 32'hFFFFFFFF || mul_q_lo !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL smull_neg1x1: q=%h_%h, need FFFFFFFF_FFFFFFFF", mul_q_hi, mul_q_lo);
        end
        launch(32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        wait_ready(cyc);
        n_checks++;
        if (mul_q_hi !== 32'h0 || mul_q_lo !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL umull_max_x1: q=%h_%h, need 00000000_FFFFFFFF", mul_q_hi, mul_q_lo);
        end
    endtask

    task automatic test_mlal;
        int cyc;
        launch(32'hFFFFFFFD, 32'd5, 32'h0, 32'h10, 1'b1, 1'b1, 1'b1);
        wait_ready(cyc);
        n_checks++;
        if (mul_q_hi !== 32'h0 || mul_q_lo !== 32'h1) begin
            n_fail++;
            $display("FAIL smlal: q=%h_%h, need 00000000_00000001", mul_q_hi, mul_q_lo);
        end
        launch(32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        wait_ready(cyc);
        n_checks++;
        if (mul_q_hi !== 32'h1 || mul_q_lo !== 32'h0) begin
            n_fail++;
            $display("FAIL umlal_carry: q=%h_%h, need 00000001_00000000", mul_q_hi, mul_q_lo);
        end
    endtask

    task automatic test_short;
        int cyc;
        // c_hi is nonzero to show it is ignored by 32-bit MLA.
        launch(32'd7, 32'd6, 32'h12345678, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0);
        wait_ready(cyc);
        n_checks++;
        if (mul_q_hi !== 32'h0 || mul_q_lo !== 32'h0000001A) begin
            n_fail++;
            $display("FAIL mla_wrap: q=%h_%h, need 00000000_0000001A", mul_q_hi, mul_q_lo);
        end
        launch(32'hFFFFFFFF, 32'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        wait_ready(cyc);
        n_checks++;
        if (mul_q_hi !== 32'h0 || mul_q_lo !== 32'hFFFFFFFE) begin
            n_fail++;
            $display("FAIL mul_signed_ignored: q=%h_%h, need 00000000_FFFFFFFE", mul_q_hi, mul_q_lo);
        end
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        wait_ready(cyc);
        n_checks++;
        if (mul_q_hi !== 32'h0 || mul_q_lo !== 32'h1) begin
            n_fail++;
            $display("FAIL mul_hi_zero: q=%h_%h, need 00000000_00000001", mul_q_hi, mul_q_lo);
        end
    endtask

    task automatic test_input_change;
        int cyc;
        launch(32'h00010001, 32'h00030002, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        // Fifth RUN cycle: new operands and a start strobe while busy.
        @(negedge clk);
        mul_a      = 32'hFFFFFFFF;
        mul_b      = 32'hFFFFFFFF;
        mul_c_hi   = 32'h11111111;
        mul_c_lo   = 32'h22222222;
        mul_add    = 1'b1;
        mul_signed = 1'b1;
        mul_start  = 1'b1;
        @(posedge clk);
        #1;
        mul_start  = 1'b0;
        wait_ready(cyc);
        n_checks++;
        if (cyc + 5 !== LAT) begin
            n_fail++;
            $display("FAIL change_latency: got %0d cycles, need %0d", cyc + 5, LAT);
        end
        n_checks++;
        if (mul_q_hi !== 32'h00000003 || mul_q_lo !== 32'h00050002) begin
            n_fail++;
            $display("FAIL change_ignored: q=%h_%h, need 00000003_00050002", mul_q_hi, mul_q_lo);
        end
        // The strobe seen while busy must not have queued a command.
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mul_ready !== 1'b1 || mul_q_lo !== 32'h00050002) begin
            n_fail++;
            $display("FAIL start_not_queued: ready=%b q_lo=%h, need 1 00050002", mul_ready, mul_q_lo);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        launch(32'd3, 32'd4, 32'h0, 32'd1, 1'b1, 1'b0, 1'b0);
        wait_ready(cyc);
        n_checks++;
        if (cyc !== LAT || mul_q_lo !== 32'h0000000D || mul_q_hi !== 32'h0) begin
            n_fail++;
            $display("FAIL b2b_first: cyc=%0d q=%h_%h, need %0d 00000000_0000000D",
                     cyc, mul_q_hi, mul_q_lo, LAT);
        end
        // Start in the same cycle ready rose.
        launch(32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (mul_ready !== 1'b0 || mul_q_lo !== 32'h0000000D) begin
            n_fail++;
            $display("FAIL b2b_accept: ready=%b q_lo=%h, need 0 0000000D", mul_ready, mul_q_lo);
        end
        wait_ready(cyc);
        n_checks++;
        if (cyc !== LAT || mul_q_hi !== 32'h0 || mul_q_lo !== 32'h6) begin
            n_fail++;
            $display("FAIL b2b_second: cyc=%0d q=%h_%h, need %0d 00000000_00000006",
                     cyc, mul_q_hi, mul_q_lo, LAT);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        mul_c_hi   = '0;
        mul_c_lo   = '0;
        mul_add    = 1'b0;
        mul_long   = 1'b0;
        mul_signed = 1'b0;
        mul_start  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        test_reset_state;
        rst_n = 1'b1;
        test_umull;
        test_reset_mid_run;
        test_smull;
        test_mlal;
        test_short;
        test_input_change;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
